// File: rtl/fc_ram_pkg.sv
// Shared types and defaults for the FC weight/bias burst memory.
// Holds the burst FSM encoding and the burst-length clamp helper.
package fc_ram_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_MAX_BURST = 120;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_burst);
        return (len > max_burst) ? max_burst : len;
    endfunction

endpackage

// File: rtl/fc_ram_core.sv
// Single-port-write / single-port-read synchronous RAM, read-first on collisions.
// Read data appears one edge after the read is issued; no stall path, always accepts.
module fc_ram_core
    import fc_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately left unreset; NBA ordering gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fc_burst_ram.sv
// FC parameter memory with a burst-read engine filling a lane-packed register; len+1 cycles to rd_valid.
// Writes always accepted; rd_start ignored while busy. Macro FC_BURST_RAM_CLEAR_EN clears rd_data on accept.
module fc_burst_ram
    import fc_ram_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_start,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [LEN_W-1:0]              rd_len,
    output logic                          rd_busy,
    output logic                          rd_valid,
    output logic [MAX_BURST*DATA_W-1:0]   rd_data
);

    state_e                        state_q;
    logic [ADDR_W-1:0]             base_q;
    logic [LEN_W-1:0]              len_q;
    logic [LEN_W-1:0]              idx_q;
    logic [LEN_W-1:0]              lane_q;
    logic                          pend_q;
    logic                          busy_q;
    logic                          valid_q;
    logic [MAX_BURST*DATA_W-1:0]   data_q;

    logic [LEN_W-1:0]              len_d;
    logic                          core_re;
    logic [ADDR_W-1:0]             core_raddr;
    logic [DATA_W-1:0]             core_rdata;

    assign len_d      = LEN_W'(clamp_len(32'(rd_len), MAX_BURST));
    assign core_re    = (state_q == FETCH);
    assign core_raddr = base_q + ADDR_W'(idx_q);

    fc_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (core_re),
        .rd_addr_i (core_raddr),
        .rd_data_o (core_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            // pend_q marks a word that left the RAM last edge and now lands in lane_q.
            if (pend_q) begin
                data_q[lane_q*DATA_W +: DATA_W] <= core_rdata;
            end
            case (state_q)
                IDLE: begin
                    if (rd_start) begin
                        base_q <= rd_addr;
                        len_q  <= len_d;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
`ifdef FC_BURST_RAM_CLEAR_EN
                        data_q <= '0;
`endif
                        state_q <= (len_d == '0) ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    pend_q <= 1'b1;
                    lane_q <= idx_q;
                    idx_q  <= idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_busy  = busy_q;
    assign rd_valid = valid_q;
    assign rd_data  = data_q;

endmodule

// File: tb/tb_fc_burst_ram.sv
// Randomized bench for fc_burst_ram against a word-level memory/lane model.
module tb_fc_burst_ram;

    localparam int DW    = 16;
    localparam int AW    = 14;
    localparam int MB    = 120;
    localparam int LW    = 7;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            rd_start;
    logic [AW-1:0]   rd_addr;
    logic [LW-1:0]   rd_len;
    logic            rd_busy;
    logic            rd_valid;
    logic [MB*DW-1:0] rd_data;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem_m  [DEPTH];
    logic [DW-1:0] lane_m [MB];
    int            sch_cyc  [2];
    logic [AW-1:0] sch_addr [2];
    logic [DW-1:0] sch_data [2];
    int            ign_cyc;
    int            lat;
    int            bcnt;

    fc_burst_ram dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_start (rd_start),
        .rd_addr  (rd_addr),
        .rd_len   (rd_len),
        .rd_busy  (rd_busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane_of(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    function automatic int first_diff();
        for (int k = 0; k < MB; k++) begin
            if (rd_data[k*DW +: DW] !== lane_m[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_lanes(input string name);
        int d;
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL %s lane=%0d got=%h exp=%h", name, d, lane_of(d), lane_m[d]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic mem_write(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr % DEPTH);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        mem_m[addr % DEPTH] = data;
    endtask

    task automatic fill_random(input int base, input int n);
        for (int k = 0; k < n; k++) mem_write(base + k, DW'($urandom));
    endtask

    // Lane j holds memory as seen at the edge that reads word j (writes at that same edge are not seen).
    task automatic run_burst(input int base, input int len);
        int eff;
        eff = (len > MB) ? MB : len;
        rd_start = 1'b1;
        rd_addr  = AW'(base % DEPTH);
        rd_len   = LW'(len);
        tick();
        rd_start = 1'b0;
`ifdef FC_BURST_RAM_CLEAR_EN
        for (int k = 0; k < MB; k++) lane_m[k] = '0;
`endif
        lat  = 0;
        bcnt = 0;
        while (rd_valid !== 1'b1 && lat < 400) begin
            if (rd_busy === 1'b1) bcnt++;
            if (lat < eff) lane_m[lat] = mem_m[(base + lat) % DEPTH];
            wr_en    = 1'b0;
            rd_start = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (sch_cyc[s] == lat) begin
                    wr_en   = 1'b1;
                    wr_addr = sch_addr[s];
                    wr_data = sch_data[s];
                    mem_m[sch_addr[s]] = sch_data[s];
                end
            end
            if (ign_cyc == lat) begin
                rd_start = 1'b1;
                rd_addr  = AW'((base + 7) % DEPTH);
                rd_len   = 7'd3;
            end
            tick();
            lat++;
        end
        wr_en      = 1'b0;
        rd_start   = 1'b0;
        sch_cyc[0] = -1;
        sch_cyc[1] = -1;
        ign_cyc    = -1;
        if (lat >= 400) begin
            checks++;
            failures++;
            $display("FAIL burst_timeout got=no_valid exp=valid_within_400");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_int("reset_busy", int'(rd_busy), 0);
        check_int("reset_valid", int'(rd_valid), 0);
        for (int k = 0; k < MB; k++) lane_m[k] = '0;
        check_lanes("reset_data");
        rst = 1'b0;
        tick();
        check_int("post_reset_busy", int'(rd_busy), 0);
    endtask

    task automatic test_full_burst();
        for (int i = 0; i < 256; i++) mem_write(i, DW'(i + 'h100));
        run_burst(10, 120);
        check_int("full_latency", lat, 121);
        check_int("full_busy_cycles", bcnt, 121);
        check_lanes("full_data");
        check_int("full_lane0", int'(lane_of(0)), 'h10A);
        check_int("full_lane119", int'(lane_of(119)), 'h181);
        tick();
        check_int("full_valid_pulse", int'(rd_valid), 0);
        check_int("full_busy_after", int'(rd_busy), 0);
    endtask

    task automatic test_collision();
        sch_cyc[0] = 5;  sch_addr[0] = 14'd5;  sch_data[0] = 16'hDEAD;
        sch_cyc[1] = 20; sch_addr[1] = 14'd50; sch_data[1] = 16'hBEEF;
        run_burst(0, 60);
        check_int("coll_latency", lat, 61);
        check_int("coll_lane5_old", int'(lane_of(5)), 'h105);
        check_int("coll_lane50_new", int'(lane_of(50)), 'hBEEF);
        check_lanes("coll_data");
        run_burst(5, 1);
        check_int("coll_write_landed", int'(lane_of(0)), 'hDEAD);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] wexp [6];
        wexp = '{16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hB0, 16'hB1};
        for (int i = 0; i < 4; i++) mem_write(16380 + i, DW'('hA0 + i));
        mem_write(0, 16'hB0);
        mem_write(1, 16'hB1);
        run_burst(16380, 6);
        check_int("wrap_latency", lat, 7);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lane_of(k) !== wexp[k]) begin
                failures++;
                $display("FAIL wrap_lane%0d got=%h exp=%h", k, lane_of(k), wexp[k]);
            end
        end
        check_lanes("wrap_data");
    endtask

    task automatic test_busy_ignore();
        int b;
        logic [DW-1:0] prev6;
        b = int'($urandom_range(0, DEPTH - 1));
        fill_random(b, 8);
        run_burst(b, 8);
        check_lanes("len8_data");
        prev6 = lane_of(6);
        fill_random(b + 20, 4);
        ign_cyc = 2;
        run_burst(b + 20, 4);
        check_int("len4_latency", lat, 5);
        check_lanes("len4_data");
`ifdef FC_BURST_RAM_CLEAR_EN
        check_int("len4_lane6", int'(lane_of(6)), 0);
`else
        check_int("len4_lane6", int'(lane_of(6)), int'(prev6));
`endif
        tick();
        check_int("ignored_start_busy", int'(rd_busy), 0);
        check_int("ignored_start_valid", int'(rd_valid), 0);
    endtask

    task automatic test_clamp_zero();
        int b;
        b = int'($urandom_range(0, DEPTH - 1));
        fill_random(b, 120);
        run_burst(b, 127);
        check_int("clamp_latency", lat, 121);
        check_int("clamp_busy_cycles", bcnt, 121);
        check_lanes("clamp_data");
        run_burst(int'($urandom_range(0, DEPTH - 1)), 0);
        check_int("zero_latency", lat, 1);
        check_int("zero_busy_cycles", bcnt, 1);
        check_lanes("zero_data");
    endtask

    task automatic test_random();
        int b;
        int len;
        int eff;
        for (int n = 0; n < 6; n++) begin
            b   = int'($urandom_range(0, DEPTH - 1));
            len = int'($urandom_range(0, 127));
            eff = (len > MB) ? MB : len;
            fill_random(b, eff);
            for (int s = 0; s < 2; s++) begin
                sch_cyc[s]  = int'($urandom_range(0, eff));
                sch_addr[s] = AW'((b + int'($urandom_range(0, eff))) % DEPTH);
                sch_data[s] = DW'($urandom);
            end
            run_burst(b, len);
            check_int("rand_latency", lat, eff + 1);
            check_lanes("rand_data");
        end
    endtask

    task automatic test_reset_mid();
        int b;
        int seen;
        b = int'($urandom_range(0, DEPTH - 1));
        fill_random(b, 60);
        rd_start = 1'b1;
        rd_addr  = AW'(b);
        rd_len   = 7'd60;
        tick();
        rd_start = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        #2;
        check_int("abort_busy", int'(rd_busy), 0);
        check_int("abort_valid", int'(rd_valid), 0);
        for (int k = 0; k < MB; k++) lane_m[k] = '0;
        check_lanes("abort_data");
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (rd_valid === 1'b1) seen++;
        end
        check_int("abort_no_valid", seen, 0);
        run_burst(b, 60);
        check_int("after_abort_latency", lat, 61);
        check_lanes("after_abort_data");
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_start   = 1'b0;
        rd_addr    = '0;
        rd_len     = '0;
        sch_cyc[0] = -1;
        sch_cyc[1] = -1;
        ign_cyc    = -1;
        for (int k = 0; k < MB; k++) lane_m[k] = '0;
        test_reset();
        test_full_burst();
        test_collision();
        test_wrap();
        test_busy_ignore();
        test_clamp_zero();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
